// File: rtl/router_pkg.sv
`default_nettype none
// =====================================================================
// Module : router_pkg
// Shared widths, header field positions and read-FSM state encoding.
// Rev    : 1.0
// =====================================================================
package router_pkg;

    localparam int PKT_LEN_W    = 6;
    localparam int ADDR_W       = 2;
    localparam int DATA_W       = 8;

    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_MSB = ADDR_W - 1;
    localparam int HDR_LEN_LSB  = ADDR_W;
    localparam int HDR_LEN_MSB  = ADDR_W + PKT_LEN_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_BODY  = 2'd2,
        ST_DRAIN = 2'd3
    } rd_state_e;

    function automatic logic [PKT_LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
        return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_skid2.sv
`default_nettype none
// =====================================================================
// Module : router_skid2
// Two-entry output buffer; entry 0 is always the head.
// Rev    : 1.0
// =====================================================================
module router_skid2
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] head_data_o,
    output logic              head_vld_o,
    output logic [1:0]        occ_o
);

    logic [DATA_W-1:0] ent0_q, ent0_d;
    logic [DATA_W-1:0] ent1_q, ent1_d;
    logic [1:0]        occ_q, occ_d;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        if (flush_i) begin
            occ_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (occ_q == 2'd0) ent0_d = push_data_i;
                    else               ent1_d = push_data_i;
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    ent0_d = ent1_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous pop and push keeps occupancy, shifting the queue
                    if (occ_q == 2'd1) begin
                        ent0_d = push_data_i;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign head_data_o = ent0_q;
    assign head_vld_o  = (occ_q != 2'd0);
    assign occ_o       = occ_q;

endmodule
`default_nettype wire

// File: rtl/router_rd_ctrl.sv
`default_nettype none
// =====================================================================
// Module : router_rd_ctrl
// Read-side packet controller: FIFO fetch, parity check, output timeout.
// Rev    : 1.0
// =====================================================================
module router_rd_ctrl
    import router_pkg::*;
#(
    parameter int TIMEOUT = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_read_enb,
    output logic              fifo_soft_reset,
    output logic [DATA_W-1:0] dout_data,
    output logic              dout_vld,
    input  logic              dout_read,
    output logic              pkt_done,
    output logic              parity_err,
    output logic              timeout
);

    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam int              REM_W   = PKT_LEN_W + 1;

    rd_state_e         state_q, state_d;
    logic [REM_W-1:0]  fetch_rem_q, fetch_rem_d, need_req;
    logic [DATA_W-1:0] parity_q, parity_d;
    logic              parity_err_q, parity_err_d;
    logic [TO_W-1:0]   stall_q, stall_d;
    logic              inflight_q, hdr_pend_q;

    logic [1:0]        occ;
    logic              accept, stall, to_fire;
    logic              hdr_arr, body_arr, last_arr, room, rd_en;

    assign accept   = dout_vld & dout_read;
    assign stall    = dout_vld & ~dout_read;
    assign to_fire  = stall & (stall_q == TO_LAST) & ~reset;
    assign hdr_arr  = inflight_q & hdr_pend_q;
    assign body_arr = inflight_q & ~hdr_pend_q;
    assign last_arr = body_arr & (fetch_rem_q == REM_W'(1));

    // Reads still to be issued, counting the byte arriving this cycle as done
    always_comb begin
        if (hdr_arr)       need_req = {1'b0, hdr_len(fifo_data)} + REM_W'(1);
        else if (body_arr) need_req = fetch_rem_q - REM_W'(1);
        else               need_req = fetch_rem_q;
    end

    assign room  = ({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, accept});
    assign rd_en = ~reset & ~fifo_empty & room &
                   ((state_q == ST_HDR) | ((state_q == ST_BODY) & (need_req != '0)));

    always_comb begin
        state_d      = state_q;
        fetch_rem_d  = fetch_rem_q;
        parity_d     = parity_q;
        parity_err_d = 1'b0;
        stall_d      = stall ? (stall_q + TO_W'(1)) : '0;

        if (hdr_arr) begin
            fetch_rem_d = need_req;
            parity_d    = fifo_data;
        end else if (body_arr) begin
            fetch_rem_d = need_req;
            if (last_arr) parity_err_d = (fifo_data != parity_q);
            else          parity_d     = parity_q ^ fifo_data;
        end

        case (state_q)
            ST_IDLE:  if (!fifo_empty)                   state_d = ST_HDR;
            ST_HDR:   if (rd_en)                         state_d = ST_BODY;
            ST_BODY:  if (last_arr)                      state_d = ST_DRAIN;
            ST_DRAIN: if (accept && (occ == 2'd1))       state_d = ST_IDLE;
            default:                                     state_d = ST_IDLE;
        endcase

        if (to_fire) begin
            state_d      = ST_IDLE;
            fetch_rem_d  = '0;
            parity_err_d = 1'b0;
            stall_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            fetch_rem_q  <= '0;
            parity_q     <= '0;
            parity_err_q <= 1'b0;
            stall_q      <= '0;
            inflight_q   <= 1'b0;
            hdr_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_rem_q  <= fetch_rem_d;
            parity_q     <= parity_d;
            parity_err_q <= parity_err_d;
            stall_q      <= stall_d;
            inflight_q   <= rd_en & ~to_fire;
            hdr_pend_q   <= rd_en & (state_q == ST_HDR) & ~to_fire;
        end
    end

    router_skid2 u_skid (
        .clk         (clk),
        .reset       (reset),
        .push_i      (inflight_q & ~to_fire),
        .push_data_i (fifo_data),
        .pop_i       (accept),
        .flush_i     (to_fire),
        .head_data_o (dout_data),
        .head_vld_o  (dout_vld),
        .occ_o       (occ)
    );

    assign fifo_read_enb   = rd_en;
    assign fifo_soft_reset = to_fire;
    assign timeout         = to_fire;
    assign parity_err      = parity_err_q;
    assign pkt_done        = ~reset & (state_q == ST_DRAIN) & accept & (occ == 2'd1);

endmodule
`default_nettype wire

// File: doc/router_rd_ctrl.md
# router_rd_ctrl

Read-side packet controller for one router output port. It drains framed packets (header, payload bytes, parity byte) from a `router_fifo` and presents them to the external destination through a valid/read handshake. It checks the XOR parity and flags per-packet completion. If the destination stops reading for too long, it times out, soft-resets the FIFO and drops the packet. One instance sits between each of the three output FIFOs and its output port.

## Interface
- `TIMEOUT`, default 30: consecutive stalled cycles (`dout_vld`=1, `dout_read`=0) before the packet is abandoned.
- `clk` in 1: clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_data` in 8: FIFO read data. It is valid the cycle after `fifo_read_enb` was high.
- `fifo_read_enb` out 1: FIFO read strobe.
- `fifo_soft_reset` out 1: one-cycle pulse that clears the FIFO on timeout.
- `dout_data` out 8: byte presented to the destination.
- `dout_vld` out 1: `dout_data` is valid.
- `dout_read` in 1: destination accepts the byte this cycle when `dout_vld`=1.
- `pkt_done` out 1: one-cycle pulse when the parity byte is accepted by the destination.
- `parity_err` out 1: one-cycle pulse when the fetched parity byte ≠ computed parity.
- `timeout` out 1: one-cycle pulse, coincident with `fifo_soft_reset`.

## Operation
- Packet format: header = {len[5:0], addr[1:0]}, then `len` payload bytes (0–63), then 1 parity byte. Total is len+2 bytes.
- Output buffer: 2-entry skid FIFO, head drives `dout_data`/`dout_vld`. An `inflight` bit marks an outstanding FIFO read.
- `fifo_read_enb`=1 iff all of the following hold:
  - the state is HDR or BODY;
  - `fifo_empty`=0;
  - (occupancy + inflight − (dout_vld & dout_read)) < 2.
- Read control FSM:
  - IDLE → HDR when `fifo_empty`=0.
  - HDR: issue exactly 1 read, then move to BODY. When the header byte arrives, latch len into `fetch_rem` = len+1 and seed parity accumulator = header.
  - BODY: issue reads while `fetch_rem`>0. Each arriving byte decrements `fetch_rem`. Payload bytes are XORed into the accumulator.
  - The last byte (parity) is compared with the accumulator. A mismatch pulses `parity_err` the cycle after it arrives. The FSM then goes to DRAIN.
  - DRAIN → IDLE when the parity byte is accepted at the output, with a `pkt_done` pulse that same cycle.
- Bytes are forwarded unmodified, in order, header included.
- Timeout:
  - A counter increments each cycle with `dout_vld`=1 and `dout_read`=0, and clears on any accept or when `dout_vld`=0.
  - On reaching `TIMEOUT`: pulse `timeout` and `fifo_soft_reset`, flush the skid buffer, discard any inflight byte, clear counters, go to IDLE.
  - No `pkt_done` or `parity_err` is raised for the dropped packet.
- Reset: state IDLE, buffer empty, inflight=0, all counters 0. All outputs 0: `dout_data`=8'h00, `dout_vld`, `fifo_read_enb`, `fifo_soft_reset`, `pkt_done`, `parity_err`, `timeout`.

## Timing
- `fifo_read_enb` is combinational from registered state and the inputs. Data is captured one cycle later.
- Latency:
  - `fifo_empty` falls in cycle N (IDLE) → `fifo_read_enb` in N+1 → header arrives N+2 → `dout_vld`=1 in N+3.
  - With `dout_read` held high, throughput is 1 byte/cycle.
- A simultaneous accept and arrival leaves occupancy unchanged, so no bubble is inserted.
- `fifo_empty` mid-packet: reads pause and the FSM holds BODY. This is not an error, but the timeout still runs if the output stalls.
- len=0: header, then parity, with accumulator = header.
- Back-to-back packets: the next HDR fetch may start in the cycle DRAIN exits. Reads for packet k+1 never occur before packet k's parity has been fetched.
- Timeout and accept in the same cycle cannot happen, because an accept clears the counter.
- `reset` overrides everything, including a timeout pulse.

## Structure
- Shared package `router_pkg`: `PKT_LEN_W`=6, `ADDR_W`=2, `DATA_W`=8, the header field slice positions, and the FSM state enum (IDLE, HDR, BODY, DRAIN).
- One sub-module: `router_skid2`, a 2-entry output buffer with push/pop/flush and occupancy output.
- Top-level file holds the FSM, the fetch counter, parity and the timeout counter.

## Test plan
- Single packet, len=14, addr=0, 14 random payload bytes, correct parity, `dout_read` tied 1 → 16 bytes out in order at 1/cycle after a 3-cycle latency; one `pkt_done`, no `parity_err`.
- Same packet with the parity byte XOR 8'h01 → `parity_err` pulses once; all 16 bytes still forwarded; `pkt_done` pulses.
- len=0 packet {6'd0,2'd2}=8'h02 followed by parity 8'h02 → 2 bytes out, no error.
- `dout_read`=0 for 30 cycles mid-payload → `timeout` and `fifo_soft_reset` pulse at stall cycle 30; `dout_vld` falls next cycle; FSM returns to IDLE; no `pkt_done`.
- Random `dout_read` (50%) and a FIFO that goes empty for 5 cycles mid-payload → no loss, duplication or reorder; `fifo_read_enb` is never high while `fifo_empty`=1; occupancy never exceeds 2.
- `reset` asserted mid-BODY for 1 cycle → all outputs 0 the next cycle; the following packet is processed correctly.
